serial_parity_checker: RTL and testbench

- Receives a serial bit stream framed as DATA_W data bits, LSB first, followed by one parity bit.
- Folds the bits through a running XOR, deserialises the data word and flags parity mismatches.
- Sits downstream of the XOR primitive stage and consumes its serial output; it presents checked words to the next stage over a valid/ready handshake.
- Keeps a saturating count of errored frames for status readout.

---
 rtl/serial_parity_checker_pkg.sv | 24 ++
 rtl/serial_parity_checker_parity_accum.sv | 22 ++
 rtl/serial_parity_checker.sv | 124 ++++++++++++
 tb/tb_serial_parity_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_parity_checker_pkg.sv
// Shared types and constants for the serial parity checker and its helpers.
package serial_parity_checker_pkg;

    // Frame reception phases: collecting data bits, awaiting parity, holding a word.
    typedef enum logic [1:0] {
        RECV = 2'd0,
        PAR  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Default frame geometry and the matching bit-counter width.
    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_ERR_CNT_W = 8;
    localparam int CNT_W             = $clog2(DEFAULT_DATA_W);

    // Saturation value of the error counter at its default width.
    localparam logic [DEFAULT_ERR_CNT_W-1:0] ERR_CNT_MAX = {DEFAULT_ERR_CNT_W{1'b1}};

    // Bit-counter width for an arbitrary data width.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/serial_parity_checker_parity_accum.sv
// One-bit XOR accumulator with synchronous clear and enable, for parity/CRC stages.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    // Fold each enabled bit into the running XOR; clear wins over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ bit_in;
        end
    end

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames with a trailing parity bit, flags parity errors
// and hands each checked word downstream over a valid/ready handshake.
module serial_parity_checker
    import serial_parity_checker_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit ODD       = 1'b0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_bit,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_par_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int                   BIT_CNT_W = cnt_width(DATA_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

    state_t               state;
    state_t               state_nxt;
    logic [BIT_CNT_W-1:0] cnt;
    logic [DATA_W-1:0]    data_sr;
    logic                 acc;
    logic                 recv_xfer;
    logic                 par_xfer;
    logic                 handshake;
    logic                 par_err_now;

    assign recv_xfer   = in_valid && (state == RECV);
    assign par_xfer    = in_valid && (state == PAR);
    assign handshake   = (state == HOLD) && out_valid && out_ready;
    assign par_err_now = acc ^ in_bit ^ ODD;

    parity_accum u_parity_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (handshake),
        .en     (recv_xfer),
        .bit_in (in_bit),
        .acc    (acc)
    );

    // Next-state selection and input readiness; HOLD refuses bits until the word leaves.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            RECV: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == LAST_BIT)) begin
                    state_nxt = PAR;
                end
            end
            PAR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_nxt = RECV;
                end
            end
            default: state_nxt = RECV;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RECV;
        end else begin
            state <= state_nxt;
        end
    end

    // Place each data bit at its frame position; the counter parks at the last slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            data_sr <= '0;
        end else if (handshake) begin
            cnt <= '0;
        end else if (recv_xfer) begin
            data_sr[cnt] <= in_bit;
            if (cnt != LAST_BIT) begin
                cnt <= cnt + BIT_CNT_W'(1);
            end
        end
    end

    // Capture the finished word on the parity bit and release it on the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
        end else if (par_xfer) begin
            out_valid   <= 1'b1;
            out_data    <= data_sr;
            out_par_err <= par_err_now;
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Count errored frames, sticking at the maximum until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (par_xfer && par_err_now && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: an even-parity and an odd-parity
// instance share one stimulus stream.
module tb_serial_parity_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_bit;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_par_err;
    logic [7:0] err_cnt;
    logic       odd_in_ready;
    logic       odd_out_valid;
    logic [7:0] odd_out_data;
    logic       odd_out_par_err;
    logic [7:0] odd_err_cnt;

    int checks = 0;
    int errors = 0;

    serial_parity_checker #(.DATA_W(8), .ODD(1'b0), .ERR_CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_par_err (out_par_err),
        .err_cnt     (err_cnt)
    );

    serial_parity_checker #(.DATA_W(8), .ODD(1'b1), .ERR_CNT_W(8)) dut_odd (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (odd_in_ready),
        .out_valid   (odd_out_valid),
        .out_ready   (out_ready),
        .out_data    (odd_out_data),
        .out_par_err (odd_out_par_err),
        .err_cnt     (odd_err_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one bit and let it transfer; gives up after a bounded wait for in_ready.
    task automatic send_bit(input logic b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_bit   = b;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_bit_timeout in_ready=%0b required=1", in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Send the 8 data bits LSB first, optionally with an idle cycle after each.
    task automatic send_data(input logic [7:0] data, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            send_bit(data[i]);
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Accept the held word with a single out_ready cycle.
    task automatic do_handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Two-cycle reset pulse.
    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("[TB] FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_par_err got=%0b exp=0", out_par_err); end
        checks++; if (err_cnt !== 8'd0)     begin errors++; $display("[TB] FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_even_parity();
        send_data(8'hA5, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL a5_valid_before_parity got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL a5_ready_for_parity got=%0b exp=1", in_ready); end
        send_bit(1'b0);
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("[TB] FAIL a5_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5)   begin errors++; $display("[TB] FAIL a5_out_data got=%h exp=a5", out_data); end
        checks++; if (out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL a5_par_err got=%0b exp=0", out_par_err); end
        checks++; if (err_cnt !== 8'd0)     begin errors++; $display("[TB] FAIL a5_err_cnt got=%0d exp=0", err_cnt); end
        checks++; if (in_ready !== 1'b0)    begin errors++; $display("[TB] FAIL a5_hold_ready got=%0b exp=0", in_ready); end
        do_handshake();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL a5_valid_after_hs got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL a5_ready_after_hs got=%0b exp=1", in_ready); end
    endtask

    task automatic test_error_count();
        send_data(8'h01, 1'b0);
        send_bit(1'b0);
        checks++; if (out_data !== 8'h01)   begin errors++; $display("[TB] FAIL e01_out_data got=%h exp=01", out_data); end
        checks++; if (out_par_err !== 1'b1) begin errors++; $display("[TB] FAIL e01_par_err got=%0b exp=1", out_par_err); end
        checks++; if (err_cnt !== 8'd1)     begin errors++; $display("[TB] FAIL e01_err_cnt got=%0d exp=1", err_cnt); end
        do_handshake();
        send_data(8'h03, 1'b0);
        send_bit(1'b0);
        checks++; if (out_data !== 8'h03)   begin errors++; $display("[TB] FAIL e03_out_data got=%h exp=03", out_data); end
        checks++; if (out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL e03_par_err got=%0b exp=0", out_par_err); end
        checks++; if (err_cnt !== 8'd1)     begin errors++; $display("[TB] FAIL e03_err_cnt got=%0d exp=1", err_cnt); end
        do_handshake();
    endtask

    task automatic test_backpressure();
        send_data(8'h3C, 1'b0);
        send_bit(1'b0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid cycle=%0d got=%0b exp=1", c, out_valid); end
            checks++; if (out_data !== 8'h3C) begin errors++; $display("[TB] FAIL bp_data cycle=%0d got=%h exp=3c", c, out_data); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL bp_ready cycle=%0d got=%0b exp=0", c, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_release got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("[TB] FAIL bp_ready_release got=%0b exp=1", in_ready); end
        send_data(8'h0F, 1'b0);
        send_bit(1'b0);
        checks++; if (out_data !== 8'h0F)   begin errors++; $display("[TB] FAIL bp_next_data got=%h exp=0f", out_data); end
        checks++; if (out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_par_err got=%0b exp=0", out_par_err); end
        checks++; if (err_cnt !== 8'd1)     begin errors++; $display("[TB] FAIL bp_err_cnt got=%0d exp=1", err_cnt); end
        do_handshake();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("[TB] FAIL mid_rst_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00)   begin errors++; $display("[TB] FAIL mid_rst_data got=%h exp=00", out_data); end
        checks++; if (out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_par_err got=%0b exp=0", out_par_err); end
        checks++; if (err_cnt !== 8'd0)     begin errors++; $display("[TB] FAIL mid_rst_err_cnt got=%0d exp=0", err_cnt); end
        send_data(8'hFF, 1'b0);
        send_bit(1'b0);
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("[TB] FAIL ff_valid got=%0b exp=1", out_valid); end
        checks++; if (out_data !== 8'hFF)   begin errors++; $display("[TB] FAIL ff_data got=%h exp=ff", out_data); end
        checks++; if (out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL ff_par_err got=%0b exp=0", out_par_err); end
        do_handshake();
    endtask

    task automatic test_gaps_odd();
        pulse_reset();
        send_data(8'h80, 1'b1);
        send_bit(1'b0);
        checks++; if (odd_out_valid !== 1'b1)   begin errors++; $display("[TB] FAIL odd_p0_valid got=%0b exp=1", odd_out_valid); end
        checks++; if (odd_out_data !== 8'h80)   begin errors++; $display("[TB] FAIL odd_p0_data got=%h exp=80", odd_out_data); end
        checks++; if (odd_out_par_err !== 1'b0) begin errors++; $display("[TB] FAIL odd_p0_par_err got=%0b exp=0", odd_out_par_err); end
        checks++; if (odd_err_cnt !== 8'd0)     begin errors++; $display("[TB] FAIL odd_p0_err_cnt got=%0d exp=0", odd_err_cnt); end
        do_handshake();
        send_data(8'h80, 1'b1);
        send_bit(1'b1);
        checks++; if (odd_out_data !== 8'h80)   begin errors++; $display("[TB] FAIL odd_p1_data got=%h exp=80", odd_out_data); end
        checks++; if (odd_out_par_err !== 1'b1) begin errors++; $display("[TB] FAIL odd_p1_par_err got=%0b exp=1", odd_out_par_err); end
        checks++; if (odd_err_cnt !== 8'd1)     begin errors++; $display("[TB] FAIL odd_p1_err_cnt got=%0d exp=1", odd_err_cnt); end
        do_handshake();
    endtask

    task automatic test_saturation();
        logic [7:0] exp_cnt;
        pulse_reset();
        for (int k = 1; k <= 257; k++) begin
            send_data(8'h01, 1'b0);
            send_bit(1'b0);
            exp_cnt = (k > 255) ? 8'd255 : 8'(k);
            checks++; if (err_cnt !== exp_cnt) begin errors++; $display("[TB] FAIL sat_err_cnt frame=%0d got=%0d exp=%0d", k, err_cnt, exp_cnt); end
            do_handshake();
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_even_parity();
        test_error_count();
        test_backpressure();
        test_reset_mid_frame();
        test_gaps_odd();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
